// File: rtl/branch_pred_if.sv
// Fetch/mem-side signal bundle for the branch target buffer.
// The master drives the lookup PC and resolved-branch updates; the slave
// (the predictor) returns the prediction and its statistics counters.
interface branch_pred_if;
    logic [15:0] pc;
    logic        redirect;
    logic        jump_pred;
    logic [15:0] jump_pred_adr;
    logic        upd_en;
    logic [15:0] upd_pc;
    logic        upd_taken;
    logic [15:0] upd_target;
    logic [15:0] hit_cnt;
    logic [15:0] upd_cnt;

    modport master (
        output pc, redirect, upd_en, upd_pc, upd_taken, upd_target,
        input  jump_pred, jump_pred_adr, hit_cnt, upd_cnt
    );

    modport slave (
        input  pc, redirect, upd_en, upd_pc, upd_taken, upd_target,
        output jump_pred, jump_pred_adr, hit_cnt, upd_cnt
    );
endinterface

// File: rtl/branch_pred.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// Lookup is combinational on the fetch PC from registered state, so a
// same-cycle update to the same index is only visible on the following cycle.
module branch_pred #(
    parameter int ENTRIES = 16
) (
    input  logic       clk,
    input  logic       reset,
    branch_pred_if.slave bp
);
    localparam int IDX_BITS = $clog2(ENTRIES);
    localparam int TAG_BITS = 16 - IDX_BITS;

    logic                r_valid  [ENTRIES];
    logic [TAG_BITS-1:0] r_tag    [ENTRIES];
    logic [15:0]         r_target [ENTRIES];
    logic [1:0]          r_ctr    [ENTRIES];
    logic [15:0]         r_pc_q;
    logic [15:0]         r_hit_cnt;
    logic [15:0]         r_upd_cnt;

    logic [IDX_BITS-1:0] w_idx;
    logic [TAG_BITS-1:0] w_tag;
    logic                w_hit;
    logic [IDX_BITS-1:0] w_uidx;
    logic [TAG_BITS-1:0] w_utag;
    logic                w_uhit;

    assign w_idx  = bp.pc[IDX_BITS-1:0];
    assign w_tag  = bp.pc[15:IDX_BITS];
    assign w_hit  = r_valid[w_idx] && (r_tag[w_idx] == w_tag);
    assign w_uidx = bp.upd_pc[IDX_BITS-1:0];
    assign w_utag = bp.upd_pc[15:IDX_BITS];
    assign w_uhit = r_valid[w_uidx] && (r_tag[w_uidx] == w_utag);

    // A recovery in fetch must never be masked, so redirect and reset both
    // kill the prediction. The target is still reported on any hit.
    assign bp.jump_pred     = w_hit & r_ctr[w_idx][1] & ~bp.redirect & ~reset;
    assign bp.jump_pred_adr = w_hit ? r_target[w_idx] : 16'h0000;
    assign bp.hit_cnt       = r_hit_cnt;
    assign bp.upd_cnt       = r_upd_cnt;

    // Table training: hit adjusts the counter, taken miss allocates over
    // whatever sits at that index, not-taken miss leaves the table alone.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                r_valid[i]  <= 1'b0;
                r_tag[i]    <= '0;
                r_target[i] <= 16'h0000;
                r_ctr[i]    <= 2'b01;
            end
        end else if (bp.upd_en) begin
            if (w_uhit) begin
                if (bp.upd_taken) begin
                    if (r_ctr[w_uidx] != 2'b11)
                        r_ctr[w_uidx] <= r_ctr[w_uidx] + 2'd1;
                    r_target[w_uidx] <= bp.upd_target;
                end else if (r_ctr[w_uidx] != 2'b00) begin
                    r_ctr[w_uidx] <= r_ctr[w_uidx] - 2'd1;
                end
            end else if (bp.upd_taken) begin
                r_valid[w_uidx]  <= 1'b1;
                r_tag[w_uidx]    <= w_utag;
                r_target[w_uidx] <= bp.upd_target;
                r_ctr[w_uidx]    <= 2'b10;
            end
        end
    end

    // Statistics: a stalled fetch (same pc as last cycle) counts its hit once.
    // pc_q resets to FFFF so the first lookup after reset always counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_q    <= 16'hFFFF;
            r_hit_cnt <= 16'h0000;
            r_upd_cnt <= 16'h0000;
        end else begin
            r_pc_q <= bp.pc;
            if (w_hit && (bp.pc != r_pc_q))
                r_hit_cnt <= r_hit_cnt + 16'd1;
            if (bp.upd_en)
                r_upd_cnt <= r_upd_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_branch_pred.sv
// Self-checking bench for branch_pred: table-driven per-cycle vectors with a
// scoreboard queue for lookup results, plus hand sequences for reset and
// counter corner cases.
`timescale 1ns/1ps
module tb_branch_pred;
    logic clk;
    logic reset;
    branch_pred_if bif();

    branch_pred #(.ENTRIES(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bp    (bif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc;
        logic        rd;
        logic        ue;
        logic [15:0] upc;
        logic        ut;
        logic [15:0] utgt;
        logic        ep;
        logic [15:0] ea;
        logic        eh;
    } vec_t;

    typedef struct {
        logic        ep;
        logic [15:0] ea;
    } exp_t;

    vec_t        tbl[$];
    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [15:0] m_hit = 16'h0;
    logic [15:0] m_upd = 16'h0;
    logic [15:0] last_pc = 16'hFFFF;

    function automatic vec_t mk(logic [15:0] pc, logic rd, logic ue, logic [15:0] upc,
                                logic ut, logic [15:0] utgt, logic ep, logic [15:0] ea, logic eh);
        vec_t v;
        v.pc = pc; v.rd = rd; v.ue = ue; v.upc = upc; v.ut = ut;
        v.utgt = utgt; v.ep = ep; v.ea = ea; v.eh = eh;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One cycle: drive after the edge, compare lookup at the falling edge,
    // then advance the counter model for the edge that commits this cycle.
    task automatic step(input vec_t v, input logic rst);
        exp_t e;
        @(posedge clk); #1;
        reset          = rst;
        bif.pc         = v.pc;
        bif.redirect   = v.rd;
        bif.upd_en     = v.ue;
        bif.upd_pc     = v.upc;
        bif.upd_taken  = v.ut;
        bif.upd_target = v.utgt;
        sb.push_back('{ep: v.ep, ea: v.ea});
        @(negedge clk);
        e = sb.pop_front();
        check($sformatf("pred pc=%h", v.pc), {15'h0, bif.jump_pred}, {15'h0, e.ep});
        check($sformatf("adr pc=%h", v.pc), bif.jump_pred_adr, e.ea);
        if (rst) begin
            m_hit = 16'h0; m_upd = 16'h0; last_pc = 16'hFFFF;
        end else begin
            if (v.eh && v.pc != last_pc) m_hit = m_hit + 16'd1;
            last_pc = v.pc;
            if (v.ue) m_upd = m_upd + 16'd1;
        end
    endtask

    // Commit the last step, go idle on the same pc, and compare counters.
    task automatic check_cnt(input string name);
        @(posedge clk); #1;
        reset = 1'b0; bif.upd_en = 1'b0; bif.redirect = 1'b0;
        last_pc = bif.pc;
        check({name, " hit_cnt"}, bif.hit_cnt, m_hit);
        check({name, " upd_cnt"}, bif.upd_cnt, m_upd);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        bif.pc = 16'h0; bif.redirect = 1'b0; bif.upd_en = 1'b0;
        bif.upd_pc = 16'h0; bif.upd_taken = 1'b0; bif.upd_target = 16'h0;

        // Reset state.
        step(mk(16'h0013, 0, 1, 16'h0013, 1, 16'h0040, 0, 16'h0000, 0), 1'b1);
        check_cnt("reset");

        // Sweep with no training: everything misses.
        for (int p = 0; p <= 16'h20; p++)
            step(mk(16'(p), 0, 0, 16'h0, 0, 16'h0, 0, 16'h0000, 0), 1'b0);
        check_cnt("sweep");

        // Allocate/train/saturate, alias, same-cycle, redirect, target update.
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 1, 16'h0040, 0, 16'h0000, 0)); // alloc, ctr10
        tbl.push_back(mk(16'h0013, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 1));
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 1, 16'h0040, 1, 16'h0040, 1)); // ->11
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 0, 16'hDEAD, 1, 16'h0040, 1)); // ->10
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 0, 16'hDEAD, 1, 16'h0040, 1)); // ->01
        tbl.push_back(mk(16'h0013, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0040, 1));
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 1, 16'h0040, 0, 16'h0040, 1)); // ->10
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 1, 16'h0040, 1, 16'h0040, 1)); // ->11
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 0, 16'hDEAD, 1, 16'h0040, 1)); // ->10
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 0, 16'hDEAD, 1, 16'h0040, 1)); // ->01
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 0, 16'hDEAD, 0, 16'h0040, 1)); // ->00
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 0, 16'hDEAD, 0, 16'h0040, 1)); // stays 00
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 0, 16'hDEAD, 0, 16'h0040, 1)); // stays 00
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 1, 16'h0040, 0, 16'h0040, 1)); // ->01
        tbl.push_back(mk(16'h0013, 0, 1, 16'h0013, 1, 16'h0040, 0, 16'h0040, 1)); // ->10
        tbl.push_back(mk(16'h0013, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 1));
        tbl.push_back(mk(16'h0023, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0)); // alias miss
        tbl.push_back(mk(16'h0023, 0, 1, 16'h0023, 1, 16'h0050, 0, 16'h0000, 0)); // conflict alloc
        tbl.push_back(mk(16'h0013, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0)); // evicted
        tbl.push_back(mk(16'h0023, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0050, 1));
        tbl.push_back(mk(16'h0005, 0, 1, 16'h0005, 1, 16'h0077, 0, 16'h0000, 0)); // same-cycle
        tbl.push_back(mk(16'h0005, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0077, 1));
        tbl.push_back(mk(16'h0005, 1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0077, 1)); // redirect
        tbl.push_back(mk(16'h0007, 0, 1, 16'h0007, 0, 16'h0088, 0, 16'h0000, 0)); // miss NT
        tbl.push_back(mk(16'h0007, 0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0));
        tbl.push_back(mk(16'h0005, 0, 1, 16'h0005, 1, 16'h0099, 1, 16'h0077, 1)); // retarget
        tbl.push_back(mk(16'h0005, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0099, 1));
        foreach (tbl[i]) step(tbl[i], 1'b0);
        check_cnt("train");

        // Mid-operation reset with a concurrent update.
        for (int k = 1; k <= 4; k++)
            step(mk(16'h0000, 0, 1, 16'(16'h30 + k), 1, 16'(16'h130 + k), 0, 16'h0000, 0), 1'b0);
        step(mk(16'h0031, 0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0131, 1), 1'b0);
        step(mk(16'h0031, 0, 1, 16'h0035, 1, 16'h0135, 0, 16'h0131, 1), 1'b1);
        check_cnt("midreset");
        for (int k = 1; k <= 5; k++)
            step(mk(16'(16'h30 + k), 0, 0, 16'h0, 0, 16'h0, 0, 16'h0000, 0), 1'b0);
        check_cnt("postreset");

        // Stalled fetch on a hit counts once.
        step(mk(16'h0000, 0, 1, 16'h0013, 1, 16'h0040, 0, 16'h0000, 0), 1'b0);
        repeat (5) step(mk(16'h0013, 0, 0, 16'h0, 0, 16'h0, 1, 16'h0040, 1), 1'b0);
        check_cnt("stall");
        check("stall hit_cnt abs", bif.hit_cnt, 16'd1);

        // upd_cnt wraps: 65537 update cycles from reset leaves 1.
        step(mk(16'h0000, 0, 0, 16'h0, 0, 16'h0, 0, 16'h0000, 0), 1'b1);
        check_cnt("wrapreset");
        begin
            int n;
            n = 65537;
            @(posedge clk); #1;
            bif.upd_pc = 16'h0007; bif.upd_taken = 1'b0; bif.upd_en = 1'b1;
            repeat (n) @(posedge clk);
            #1 bif.upd_en = 1'b0;
            m_upd = 16'(n % 65536);
            check("wrap upd_cnt", bif.upd_cnt, m_upd);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/branch_pred.md
Name: branch_pred

Overview:
Branch target buffer with 2-bit saturating direction counters, directly upstream of the fetch stage. It produces jump_pred and jump_pred_adr for fetch's next-PC selection. Lookup is combinational on the current fetch PC. Resolved branch outcomes from the mem stage train the table on the clock edge.

Parameters:
ENTRIES, 16, number of BTB entries; power of two, 2..256.
IDX_BITS, $clog2(ENTRIES), index width; derived, not overridden.

Ports:
clk  input  1  clock, rising edge
reset  input  1  synchronous, active-high reset
pc  input  16  current fetch PC (fetch stage register output)
redirect  input  1  fetch recovery this cycle (jump_pred_miss | jump_pred_adr_miss); suppresses prediction
jump_pred  output  1  predict taken for pc; combinational
jump_pred_adr  output  16  predicted target; combinational
upd_en  input  1  a branch/jump resolved this cycle in mem
upd_pc  input  16  PC of the resolved branch
upd_taken  input  1  actual direction
upd_target  input  16  actual target (ALUres_mem)
hit_cnt  output  16  lookups that hit a valid entry, sampled only when the fetch PC advances; wraps
upd_cnt  output  16  number of update cycles; wraps

Behaviour:
- Entry fields: valid (1), tag (16-IDX_BITS), target (16), ctr (2).
- Indexing: idx = pc[IDX_BITS-1:0]; tag = pc[15:IDX_BITS]. The same split applies to upd_pc.
- Counter encoding: 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T.
- Lookup is combinational from registered state; zero latency.
  - hit = valid[idx] & (tag[idx] == pc tag).
  - jump_pred = hit & ctr[idx][1] & ~redirect & ~reset.
  - jump_pred_adr = target[idx] whenever hit, else 16'h0000. It is don't-care when jump_pred=0, but the bench checks 0 on a miss.
- redirect forces jump_pred=0. Fetch gives jump_pred priority over its miss-recovery paths, so the predictor must never mask a recovery.
- Update, on the rising edge when upd_en=1, at u_idx/u_tag:
  - Hit, taken: ctr saturating increment (11 stays 11); target <= upd_target.
  - Hit, not taken: ctr saturating decrement (00 stays 00); target unchanged.
  - Miss, taken: allocate. valid<=1, tag<=u_tag, target<=upd_target, ctr<=10. This overwrites any entry with a different tag.
  - Miss, not taken: no state change.
- Simultaneous lookup and update to the same index: the lookup returns the pre-update contents. New contents are visible the next cycle. There is no write-to-read bypass.
- Reset (synchronous, any cycle, including mid-training):
  - All valid <= 0, ctr <= 01, target <= 0, tag <= 0.
  - hit_cnt <= 0, upd_cnt <= 0.
  - jump_pred = 0 while reset is high.
  - A concurrent upd_en is ignored.
- hit_cnt increments when hit=1 and pc differs from the previous cycle's pc (tracked by an internal pc_q register, reset to 16'hFFFF). A stalled fetch therefore counts once.
- upd_cnt increments on every cycle with upd_en=1 and reset=0.
- Both counters wrap from FFFF to 0000.
- No X on outputs after the first reset edge.

Test Plan:
- Reset then pc sweep 0x0000..0x0020 with no updates -> jump_pred=0, jump_pred_adr=0, hit_cnt=0 throughout.
- Allocate, then train:
  - Update upd_pc=0x0013, taken, target=0x0040 -> next cycle pc=0x0013 gives jump_pred=1, adr=0x0040 (ctr=10).
  - Second taken update -> ctr=11.
  - Two not-taken updates -> ctr=01 and jump_pred=0, hit still counted.
- Saturation: three not-taken updates from 11, then two more -> ctr stays 00. Two taken updates -> ctr reaches 10 and jump_pred=1.
- Alias and conflict:
  - Allocate 0x0013 -> pc=0x0023 (same idx, different tag) gives jump_pred=0.
  - Taken update at 0x0023, target 0x0050 -> pc=0x0013 misses; pc=0x0023 predicts 0x0050.
- Same-cycle read/write:
  - With the entry absent, pc=0x0005 and allocating update at 0x0005 in the same cycle -> jump_pred=0 that cycle, 1 the next.
  - redirect=1 on a predicted-taken hit -> jump_pred=0.
- Reset mid-operation and counters:
  - Train 4 entries, assert reset with upd_en=1 -> all lookups miss afterwards; hit_cnt=upd_cnt=0.
  - Hold pc=0x0013 (hit) for 5 cycles -> hit_cnt increments by 1.
  - 65537 update cycles -> upd_cnt=1.
